sub_sequence_generator: RTL and testbench
=========================================

SUB_SEQUENCE_GENERATOR -- requirements
Module: sub_sequence_generator

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: frame request, sampled each cycle.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-006 The block SHALL have port N, input, 6 bits: run length of the 1-run and of the 0-run in sub-sequence A.
REQ-007 The block SHALL have port M, input, 5 bits: number of A repetitions per frame.
REQ-008 The block SHALL have port data_out, output, 1 bit: serial bit stream, registered.
REQ-009 The block SHALL have port data_vld, output, 1 bit: qualifies data_out, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is in progress, registered.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse at normal frame completion, registered.

Function
REQ-012 A is defined as N ones followed by N zeros; a frame SHALL be M consecutive copies of A (2*N*M bits) with no gaps.
REQ-013 start SHALL be accepted only when busy=0 and abort=0; start while busy=1 SHALL be ignored.
REQ-014 N and M SHALL be captured into internal registers on acceptance; later input changes SHALL NOT affect the running frame.
REQ-015 Acceptance at cycle t SHALL make data_vld=1 and busy=1 for cycles t+1 .. t+2NM.
REQ-016 Bit k (0-based) of the frame SHALL be 1 if (k mod 2N) < N, else 0.
REQ-017 The FSM SHALL have states IDLE, ONES, ZEROS, GAP, and FIN.
REQ-018 FSM transitions SHALL be: IDLE->ONES on accept; ONES->ZEROS after N bits; ZEROS->ONES after N bits when fewer than M reps are done; ZEROS->GAP after the M-th rep, or ZEROS->FIN when the gap is disabled or zero-length; GAP->FIN; FIN->IDLE.
REQ-019 Internal counters SHALL be: a 6-bit bit counter (0..N-1, cleared at each run change) and a 5-bit rep counter (0..M-1, incremented at each ZEROS->ONES); counters SHALL NOT wrap past their limits.
REQ-020 In FIN, done=1 and busy=0 SHALL hold for exactly one cycle, at cycle t+2NM+1 when no gap is inserted.
REQ-021 A start presented in the done cycle SHALL be accepted, so back-to-back frames are separated by exactly one idle cycle.
REQ-022 If the captured N=0 or M=0, the block SHALL emit no data_vld and SHALL pulse done at t+1.
REQ-023 abort=1 in any cycle SHALL return the FSM to IDLE at the next edge, with data_vld=0, data_out=0, busy=0, and no done pulse.
REQ-024 When abort and start are both high while idle, abort SHALL win and the frame SHALL NOT start.
REQ-025 When data_vld=0, data_out SHALL be 0.

Reset
REQ-026 On rst=1, the block SHALL immediately force the state to IDLE, both counters to 0, the captured N/M to 0, and data_out, data_vld, busy, done to 0.
REQ-027 Reset mid-frame SHALL discard the frame; after rst deasserts, no output SHALL change until a new start is accepted.

Configuration
REQ-028 Macro SUB_SEQUENCE_GENERATOR_GAP_EN, when defined, SHALL add input gap_len (4 bits), captured on acceptance.
REQ-029 With SUB_SEQUENCE_GENERATOR_GAP_EN defined, after the last frame bit the block SHALL stay in GAP for gap_len cycles (busy=1, data_vld=0, data_out=0), with done at t+2NM+gap_len+1; gap_len=0 SHALL skip GAP.
REQ-030 Without SUB_SEQUENCE_GENERATOR_GAP_EN, the gap_len port and the GAP state logic SHALL be absent, and behaviour SHALL be as if gap_len=0.

Verification
REQ-031 The bench SHALL check N=3, M=2, start at t: data_out at t+1..t+12 = 111000111000 with data_vld=1, done=1 at t+13, busy low at t+13.
REQ-032 The bench SHALL check start during a frame (N=4, M=1; start re-pulsed at t+3 with N=1): the stream stays 11110000, with a single done at t+9.
REQ-033 The bench SHALL check N=0, M=5: no data_vld, done=1 at t+1; and N=2, M=0: the same result.
REQ-034 The bench SHALL check N=2, M=3 with abort at t+5: data_vld=0 and busy=0 from t+6, with no done in the following 20 cycles.
REQ-035 The bench SHALL check rst asserted at t+4 of an N=5, M=2 frame: all outputs go 0 asynchronously, with no activity after release until the next start.
REQ-036 The bench SHALL check, with SUB_SEQUENCE_GENERATOR_GAP_EN, N=1, M=2, gap_len=3: stream 1010, then 3 cycles with busy=1 and data_vld=0, done at t+8, and a start in that done cycle giving a new first bit at t+9.

Source files
------------

// File: rtl/sub_sequence_generator.sv
// Serial frame generator: emits M back-to-back copies of (N ones, N zeros).
// Optional trailing idle gap enabled by defining SUB_SEQUENCE_GENERATOR_GAP_EN.
module sub_sequence_generator (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] N,
    input  logic [4:0] M,
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
    input  logic [3:0] gap_len,
`endif
    output logic       data_out,
    output logic       data_vld,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ONES  = 3'd1,
        ST_ZEROS = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t     state_r, state_s;
    logic [5:0] bit_cnt_r, bit_cnt_s;
    logic [4:0] rep_cnt_r, rep_cnt_s;
    logic [5:0] n_r, n_s;
    logic [4:0] m_r, m_s;
    logic       data_out_s, data_vld_s, busy_s, done_s;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
    logic [3:0] gap_r, gap_s;
    logic [3:0] gap_cnt_r, gap_cnt_s;
`endif

    // State, counters, captured parameters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 6'd0;
            rep_cnt_r <= 5'd0;
            n_r       <= 6'd0;
            m_r       <= 5'd0;
            data_out  <= 1'b0;
            data_vld  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
            gap_r     <= 4'd0;
            gap_cnt_r <= 4'd0;
`endif
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            rep_cnt_r <= rep_cnt_s;
            n_r       <= n_s;
            m_r       <= m_s;
            data_out  <= data_out_s;
            data_vld  <= data_vld_s;
            busy      <= busy_s;
            done      <= done_s;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
            gap_r     <= gap_s;
            gap_cnt_r <= gap_cnt_s;
`endif
        end
    end

    // Next-state and counter logic; FIN accepts start like IDLE for back-to-back frames
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        rep_cnt_s = rep_cnt_r;
        n_s       = n_r;
        m_s       = m_r;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
        gap_s     = gap_r;
        gap_cnt_s = gap_cnt_r;
`endif
        if (abort) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 6'd0;
            rep_cnt_s = 5'd0;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
            gap_cnt_s = 4'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        n_s       = N;
                        m_s       = M;
                        bit_cnt_s = 6'd0;
                        rep_cnt_s = 5'd0;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
                        gap_s     = gap_len;
                        gap_cnt_s = 4'd0;
`endif
                        if ((N == 6'd0) || (M == 5'd0)) begin
                            state_s = ST_FIN;
                        end else begin
                            state_s = ST_ONES;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ONES: begin
                    if (bit_cnt_r == (n_r - 6'd1)) begin
                        state_s   = ST_ZEROS;
                        bit_cnt_s = 6'd0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 6'd1;
                    end
                end
                ST_ZEROS: begin
                    if (bit_cnt_r == (n_r - 6'd1)) begin
                        bit_cnt_s = 6'd0;
                        if (rep_cnt_r == (m_r - 5'd1)) begin
                            rep_cnt_s = 5'd0;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
                            state_s = (gap_r != 4'd0) ? ST_GAP : ST_FIN;
`else
                            state_s = ST_FIN;
`endif
                        end else begin
                            rep_cnt_s = rep_cnt_r + 5'd1;
                            state_s   = ST_ONES;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 6'd1;
                    end
                end
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
                ST_GAP: begin
                    if (gap_cnt_r == (gap_r - 4'd1)) begin
                        gap_cnt_s = 4'd0;
                        state_s   = ST_FIN;
                    end else begin
                        gap_cnt_s = gap_cnt_r + 4'd1;
                    end
                end
`endif
                default: begin
                    state_s   = ST_IDLE;
                    bit_cnt_s = 6'd0;
                    rep_cnt_s = 5'd0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so the registered copies line up with it
    always_comb begin
        data_out_s = 1'b0;
        data_vld_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_s)
            ST_ONES: begin
                data_out_s = 1'b1;
                data_vld_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_ZEROS: begin
                data_vld_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_GAP: begin
                busy_s = 1'b1;
            end
            ST_FIN: begin
                done_s = 1'b1;
            end
            default: begin
                data_out_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sub_sequence_generator.sv
// Directed self-checking bench for sub_sequence_generator; the gap scenario
// runs only when SUB_SEQUENCE_GENERATOR_GAP_EN is defined.
module tb_sub_sequence_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] n_in = 6'd0;
    logic [4:0] m_in = 5'd0;
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
    logic [3:0] gap_len = 4'd0;
`endif
    logic       data_out, data_vld, busy, done;

    int tests_run = 0;
    int tests_failed = 0;

    sub_sequence_generator dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .N        (n_in),
        .M        (m_in),
`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
        .gap_len  (gap_len),
`endif
        .data_out (data_out),
        .data_vld (data_vld),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"}, {31'd0, data_vld}, 32'd0);
        chk({tag, "_out"}, {31'd0, data_out}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [11:0] pat12;
        logic [7:0]  pat8;
        int          done_cnt;

        // reset state
        #2;
        chk_idle("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_idle("post_reset");

        // N=3, M=2: 111000111000, done at t+13
        pat12 = 12'b111000111000;
        n_in = 6'd3; m_in = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("f1_vld", {31'd0, data_vld}, 32'd1);
            chk("f1_bit", {31'd0, data_out}, {31'd0, pat12[11-k]});
            chk("f1_busy", {31'd0, busy}, 32'd1);
            chk("f1_nodone", {31'd0, done}, 32'd0);
            tick();
        end
        chk("f1_done", {31'd0, done}, 32'd1);
        chk("f1_busy_lo", {31'd0, busy}, 32'd0);
        chk("f1_vld_lo", {31'd0, data_vld}, 32'd0);
        tick();
        chk_idle("f1_after");

        // N=4, M=1 with a start re-pulse at t+3 carrying N=1: ignored
        pat8 = 8'b11110000;
        n_in = 6'd4; m_in = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("f2_vld", {31'd0, data_vld}, 32'd1);
            chk("f2_bit", {31'd0, data_out}, {31'd0, pat8[7-k]});
            chk("f2_nodone", {31'd0, done}, 32'd0);
            if (k == 2) begin
                n_in = 6'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("f2_done", {31'd0, done}, 32'd1);
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("f2_single_done", done_cnt, 32'd0);

        // N=0, M=5 and N=2, M=0: done at t+1 with no data
        n_in = 6'd0; m_in = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("n0_done", {31'd0, done}, 32'd1);
        chk("n0_vld", {31'd0, data_vld}, 32'd0);
        chk("n0_busy", {31'd0, busy}, 32'd0);
        tick();
        chk_idle("n0_after");
        n_in = 6'd2; m_in = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("m0_done", {31'd0, done}, 32'd1);
        chk("m0_vld", {31'd0, data_vld}, 32'd0);
        tick();
        chk_idle("m0_after");

        // abort and start together while idle: abort wins
        n_in = 6'd2; m_in = 5'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_idle("abort_start");

        // N=2, M=3 aborted at t+5
        n_in = 6'd2; m_in = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        chk("ab_vld_pre", {31'd0, data_vld}, 32'd1);
        chk("ab_bit_pre", {31'd0, data_out}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("ab_t6");
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy || data_vld) done_cnt++;
        end
        chk("ab_quiet20", done_cnt, 32'd0);

        // async reset at t+4 of N=5, M=2
        n_in = 6'd5; m_in = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 4; k++) tick();
        chk("rs_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("rs_async");
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy || data_vld || data_out) done_cnt++;
        end
        chk("rs_quiet", done_cnt, 32'd0);

        // minimal frame after reset: N=1, M=1 -> 10, done at t+3
        n_in = 6'd1; m_in = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("min_b0", {31'd0, data_out}, 32'd1);
        chk("min_v0", {31'd0, data_vld}, 32'd1);
        tick();
        chk("min_b1", {31'd0, data_out}, 32'd0);
        chk("min_v1", {31'd0, data_vld}, 32'd1);
        tick();
        chk("min_done", {31'd0, done}, 32'd1);
        tick();

`ifdef SUB_SEQUENCE_GENERATOR_GAP_EN
        // N=1, M=2, gap 3: 1010, three gap cycles, done at t+8, back-to-back start
        pat8 = 8'b00001010;
        n_in = 6'd1; m_in = 5'd2; gap_len = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("g_vld", {31'd0, data_vld}, 32'd1);
            chk("g_bit", {31'd0, data_out}, {31'd0, pat8[3-k]});
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk("g_gap_busy", {31'd0, busy}, 32'd1);
            chk("g_gap_vld", {31'd0, data_vld}, 32'd0);
            chk("g_gap_out", {31'd0, data_out}, 32'd0);
            chk("g_gap_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("g_done", {31'd0, done}, 32'd1);
        chk("g_done_busy", {31'd0, busy}, 32'd0);
        n_in = 6'd2; m_in = 5'd1; gap_len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("g_b2b_vld", {31'd0, data_vld}, 32'd1);
        chk("g_b2b_bit", {31'd0, data_out}, 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("g_b2b_done", {31'd0, done}, 32'd1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
